// File: rtl/reg_port_arbiter.sv
// Three-port round-robin arbiter in front of a single-port register file.
// The winner keeps the port for up to MAX_HOLD accesses, then a one-cycle idle bubble follows.
module reg_port_arbiter #(
    parameter int DATA_W   = 4,
    parameter int ADDR_W   = 3,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        req,
    input  logic [2:0]        wr,
    input  logic [ADDR_W-1:0] addr_0,
    input  logic [ADDR_W-1:0] addr_1,
    input  logic [ADDR_W-1:0] addr_2,
    input  logic [DATA_W-1:0] data_0,
    input  logic [DATA_W-1:0] data_1,
    input  logic [DATA_W-1:0] data_2,
    input  logic [DATA_W-1:0] rf_d_out,
    output logic [2:0]        gnt,
    output logic [ADDR_W-1:0] rf_addr,
    output logic              rf_wr_en,
    output logic [DATA_W-1:0] rf_d_in,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [1:0]        rd_id,
    output logic              busy
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t            state_reg;
    logic [1:0]        ptr_reg;
    logic [1:0]        win_reg;
    logic [3:0]        hold_reg;
    logic [2:0]        gnt_reg;
    logic [DATA_W-1:0] rd_data_reg;
    logic              rd_valid_reg;
    logic [1:0]        rd_id_reg;

    logic [ADDR_W-1:0] addr_arr [3];
    logic [DATA_W-1:0] data_arr [3];

    assign addr_arr[0] = addr_0;
    assign addr_arr[1] = addr_1;
    assign addr_arr[2] = addr_2;
    assign data_arr[0] = data_0;
    assign data_arr[1] = data_1;
    assign data_arr[2] = data_2;

    // Round-robin pick: scan from ptr downwards in priority so the nearest candidate wins.
    logic [1:0] pick_next;
    logic [2:0] cand;
    always_comb begin
        pick_next = ptr_reg;
        cand      = '0;
        for (int k = 2; k >= 0; k--) begin
            cand = {1'b0, ptr_reg} + 3'(k);
            if (cand > 3'd2)
                cand = cand - 3'd3;
            if (req[cand[1:0]])
                pick_next = cand[1:0];
        end
    end

    // gnt_reg is zero in IDLE, so masking by it also qualifies the state.
    logic       access;
    logic       wr_sel;
    logic [3:0] hold_next;
    logic       release_now;

    assign access      = |(req & gnt_reg);
    assign wr_sel      = |(wr & gnt_reg);
    assign hold_next   = hold_reg + 4'd1;
    assign release_now = (state_reg == GRANT) && (!access || hold_next == 4'(MAX_HOLD));

    always_comb begin
        rf_addr = '0;
        rf_d_in = '0;
        if (state_reg == GRANT) begin
            rf_addr = addr_arr[win_reg];
            rf_d_in = data_arr[win_reg];
        end
    end

    assign rf_wr_en = access & wr_sel & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            ptr_reg      <= 2'd0;
            win_reg      <= 2'd0;
            hold_reg     <= 4'd0;
            gnt_reg      <= 3'b000;
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
            rd_id_reg    <= 2'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    rd_valid_reg <= 1'b0;
                    if (|req) begin
                        state_reg <= GRANT;
                        win_reg   <= pick_next;
                        gnt_reg   <= 3'b001 << pick_next;
                        hold_reg  <= 4'd0;
                    end
                end
                GRANT: begin
                    rd_valid_reg <= access & ~wr_sel;
                    if (access) begin
                        hold_reg <= hold_next;
                        if (!wr_sel) begin
                            rd_data_reg <= rf_d_out;
                            rd_id_reg   <= win_reg;
                        end
                    end
                    if (release_now) begin
                        state_reg <= IDLE;
                        gnt_reg   <= 3'b000;
                        ptr_reg   <= (win_reg == 2'd2) ? 2'd0 : win_reg + 2'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign gnt      = gnt_reg;
    assign busy     = (state_reg == GRANT);
    assign rd_data  = rd_data_reg;
    assign rd_valid = rd_valid_reg;
    assign rd_id    = rd_id_reg;

endmodule

// File: tb/tb_reg_port_arbiter.sv
// Bench for reg_port_arbiter: directed scenarios plus random traffic against a cycle model.
// Inputs change just after the falling edge; outputs are sampled 1 time unit later.
module tb_reg_port_arbiter;

    localparam int DATA_W   = 4;
    localparam int ADDR_W   = 3;
    localparam int MAX_HOLD = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [2:0]        req, wr;
    logic [ADDR_W-1:0] addr_0, addr_1, addr_2;
    logic [DATA_W-1:0] data_0, data_1, data_2;
    logic [DATA_W-1:0] rf_d_out;
    logic [2:0]        gnt;
    logic [ADDR_W-1:0] rf_addr;
    logic              rf_wr_en;
    logic [DATA_W-1:0] rf_d_in;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [1:0]        rd_id;
    logic              busy;

    int n_cmp = 0;
    int n_err = 0;

    // Register file seen by the DUT, and the model's private copy of it.
    logic [DATA_W-1:0] mem     [8];
    logic [DATA_W-1:0] ref_mem [8];

    // Reference model state.
    int                m_owner;
    int                m_served;
    int                m_start;
    logic              m_rdv;
    logic [DATA_W-1:0] m_rdd;
    logic [1:0]        m_rid;

    reg_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst(rst), .req(req), .wr(wr),
        .addr_0(addr_0), .addr_1(addr_1), .addr_2(addr_2),
        .data_0(data_0), .data_1(data_1), .data_2(data_2),
        .rf_d_out(rf_d_out), .gnt(gnt), .rf_addr(rf_addr), .rf_wr_en(rf_wr_en),
        .rf_d_in(rf_d_in), .rd_data(rd_data), .rd_valid(rd_valid), .rd_id(rd_id),
        .busy(busy)
    );

    always #5 clk = ~clk;

    assign rf_d_out = mem[rf_addr];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) mem[i] <= 4'(i * 3 + 1);
        end else if (rf_wr_en) begin
            mem[rf_addr] <= rf_d_in;
        end
    end

    function automatic logic [ADDR_W-1:0] sel_addr(int i);
        case (i)
            0:       return addr_0;
            1:       return addr_1;
            default: return addr_2;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] sel_data(int i);
        case (i)
            0:       return data_0;
            1:       return data_1;
            default: return data_2;
        endcase
    endfunction

    task automatic clear_inputs();
        req = 3'b000; wr = 3'b000;
        addr_0 = '0; addr_1 = '0; addr_2 = '0;
        data_0 = '0; data_1 = '0; data_2 = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_owner = -1; m_served = 0; m_start = 0;
        m_rdv = 1'b0; m_rdd = '0; m_rid = 2'd0;
        for (int i = 0; i < 8; i++) ref_mem[i] = 4'(i * 3 + 1);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if ({gnt, busy, rf_wr_en, rf_addr, rf_d_in, rd_valid, rd_id, rd_data} !== '0) begin
            $display("FAIL reset_outputs: got %h required 0",
                     {gnt, busy, rf_wr_en, rf_addr, rf_d_in, rd_valid, rd_id, rd_data});
            n_err++;
        end
        req = 3'b111;
        @(negedge clk); #1;
        n_cmp++;
        if ({gnt, busy} !== 4'b0000) begin
            $display("FAIL reset_holds_idle: got gnt=%b busy=%b required 000/0", gnt, busy);
            n_err++;
        end
        rst = 1'b0;
        @(negedge clk); #1;
        n_cmp++;
        if (gnt !== 3'b001) begin
            $display("FAIL reset_first_search: got gnt=%b required 001", gnt);
            n_err++;
        end
        $display("test_reset done");
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_g [11] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b000,
                                   3'b010, 3'b010, 3'b010, 3'b010, 3'b000, 3'b100};
        logic [ADDR_W-1:0] exp_a;
        do_reset();
        req = 3'b111; wr = 3'b000;
        addr_0 = 3'd1; addr_1 = 3'd4; addr_2 = 3'd6;
        for (int j = 0; j < 11; j++) begin
            @(negedge clk); #1;
            case (exp_g[j])
                3'b001:  exp_a = 3'd1;
                3'b010:  exp_a = 3'd4;
                3'b100:  exp_a = 3'd6;
                default: exp_a = 3'd0;
            endcase
            n_cmp++;
            if ({gnt, busy, rf_addr, rf_wr_en} !== {exp_g[j], |exp_g[j], exp_a, 1'b0}) begin
                $display("FAIL rr_cycle%0d: got gnt=%b busy=%b addr=%0d we=%b required gnt=%b addr=%0d we=0",
                         j, gnt, busy, rf_addr, rf_wr_en, exp_g[j], exp_a);
                n_err++;
            end
            if (j == 4 || j == 9) begin
                n_cmp++;
                if ({rd_valid, rd_id, rd_data} !== ((j == 4) ? {1'b1, 2'd0, 4'h4} : {1'b1, 2'd1, 4'hD})) begin
                    $display("FAIL rr_read%0d: got valid=%b id=%0d data=%h", j, rd_valid, rd_id, rd_data);
                    n_err++;
                end
            end
        end
        $display("test_round_robin done");
    endtask

    task automatic test_loader_write();
        do_reset();
        addr_1 = 3'd5; data_1 = 4'hA; wr = 3'b010; req = 3'b010;
        @(negedge clk); #1;
        n_cmp++;
        if ({gnt, busy, rf_wr_en, rf_addr, rf_d_in} !== {3'b010, 1'b1, 1'b1, 3'd5, 4'hA}) begin
            $display("FAIL loader_access: got gnt=%b busy=%b we=%b addr=%0d din=%h required 010/1/1/5/a",
                     gnt, busy, rf_wr_en, rf_addr, rf_d_in);
            n_err++;
        end
        @(negedge clk);
        req = 3'b000;
        #1;
        n_cmp++;
        if ({gnt, rf_wr_en, rf_addr, rf_d_in} !== {3'b010, 1'b0, 3'd5, 4'hA}) begin
            $display("FAIL loader_no_access: got gnt=%b we=%b addr=%0d din=%h required 010/0/5/a",
                     gnt, rf_wr_en, rf_addr, rf_d_in);
            n_err++;
        end
        @(negedge clk); #1;
        n_cmp++;
        if ({gnt, busy, mem[5]} !== {3'b000, 1'b0, 4'hA}) begin
            $display("FAIL loader_release: got gnt=%b busy=%b mem5=%h required 000/0/a", gnt, busy, mem[5]);
            n_err++;
        end
        $display("test_loader_write done");
    endtask

    task automatic test_exec_read();
        do_reset();
        addr_0 = 3'd2; wr = 3'b000; req = 3'b001;
        @(negedge clk); #1;
        n_cmp++;
        if ({gnt, rf_addr, rf_wr_en, rf_d_out, rd_valid} !== {3'b001, 3'd2, 1'b0, 4'h7, 1'b0}) begin
            $display("FAIL exec_access: got gnt=%b addr=%0d we=%b dout=%h valid=%b",
                     gnt, rf_addr, rf_wr_en, rf_d_out, rd_valid);
            n_err++;
        end
        @(negedge clk);
        req = 3'b000;
        #1;
        n_cmp++;
        if ({rd_valid, rd_data, rd_id} !== {1'b1, 4'h7, 2'd0}) begin
            $display("FAIL exec_rd_pulse: got valid=%b data=%h id=%0d required 1/7/0", rd_valid, rd_data, rd_id);
            n_err++;
        end
        @(negedge clk); #1;
        n_cmp++;
        if ({rd_valid, rd_data, gnt} !== {1'b0, 4'h7, 3'b000}) begin
            $display("FAIL exec_rd_hold: got valid=%b data=%h gnt=%b required 0/7/000", rd_valid, rd_data, gnt);
            n_err++;
        end
        $display("test_exec_read done");
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req = 3'b100; wr = 3'b100; addr_2 = 3'd3; data_2 = 4'h5;
        @(negedge clk); #1;
        n_cmp++;
        if ({gnt, rf_wr_en} !== {3'b100, 1'b1}) begin
            $display("FAIL dbg_first_write: got gnt=%b we=%b required 100/1", gnt, rf_wr_en);
            n_err++;
        end
        @(negedge clk); #1;
        n_cmp++;
        if ({gnt, rf_wr_en} !== {3'b100, 1'b1}) begin
            $display("FAIL dbg_second_write: got gnt=%b we=%b required 100/1", gnt, rf_wr_en);
            n_err++;
        end
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if ({gnt, rf_wr_en, busy, rd_valid} !== 6'b0) begin
            $display("FAIL async_reset: got gnt=%b we=%b busy=%b valid=%b required all 0",
                     gnt, rf_wr_en, busy, rd_valid);
            n_err++;
        end
        @(negedge clk);
        rst = 1'b0; req = 3'b111; wr = 3'b000;
        @(negedge clk); #1;
        n_cmp++;
        if (gnt !== 3'b001) begin
            $display("FAIL post_reset_grant: got gnt=%b required 001", gnt);
            n_err++;
        end
        $display("test_reset_mid_grant done");
    endtask

    task automatic test_drop_release();
        logic [2:0] exp_g [6] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b000, 3'b001};
        do_reset();
        req = 3'b011; wr = 3'b000;
        @(negedge clk); #1;
        n_cmp++;
        if (gnt !== 3'b001) begin
            $display("FAIL drop_first_grant: got gnt=%b required 001", gnt);
            n_err++;
        end
        @(negedge clk);
        req = 3'b010;
        #1;
        n_cmp++;
        if ({gnt, busy} !== {3'b001, 1'b1}) begin
            $display("FAIL drop_still_granted: got gnt=%b busy=%b required 001/1", gnt, busy);
            n_err++;
        end
        @(negedge clk);
        req = 3'b011;
        #1;
        n_cmp++;
        if (gnt !== 3'b000) begin
            $display("FAIL drop_release: got gnt=%b required 000", gnt);
            n_err++;
        end
        for (int j = 0; j < 6; j++) begin
            @(negedge clk); #1;
            n_cmp++;
            if (gnt !== exp_g[j]) begin
                $display("FAIL drop_regrant%0d: got gnt=%b required %b", j, gnt, exp_g[j]);
                n_err++;
            end
        end
        $display("test_drop_release done");
    endtask

    task automatic test_random();
        logic [2:0]        exp_g;
        logic              acc;
        logic              exp_we;
        logic [ADDR_W-1:0] exp_a;
        logic [DATA_W-1:0] exp_d;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int b = 0; b < 3; b++) req[b] = ($urandom_range(0, 9) < 8);
            wr     = 3'($urandom_range(0, 7));
            addr_0 = 3'($urandom_range(0, 7));
            addr_1 = 3'($urandom_range(0, 7));
            addr_2 = 3'($urandom_range(0, 7));
            data_0 = 4'($urandom_range(0, 15));
            data_1 = 4'($urandom_range(0, 15));
            data_2 = 4'($urandom_range(0, 15));
            #1;
            exp_g  = (m_owner < 0) ? 3'b000 : (3'b001 << m_owner);
            acc    = (m_owner >= 0) && req[m_owner];
            exp_we = acc && wr[m_owner];
            exp_a  = (m_owner < 0) ? '0 : sel_addr(m_owner);
            exp_d  = (m_owner < 0) ? '0 : sel_data(m_owner);
            n_cmp++;
            if ({gnt, busy, rf_wr_en, rf_addr, rf_d_in, rd_valid, rd_id, rd_data} !==
                {exp_g, m_owner >= 0, exp_we, exp_a, exp_d, m_rdv, m_rid, m_rdd}) begin
                $display("FAIL random_cycle%0d: got gnt=%b busy=%b we=%b addr=%0d din=%h v=%b id=%0d rd=%h required gnt=%b we=%b addr=%0d din=%h v=%b id=%0d rd=%h",
                         cyc, gnt, busy, rf_wr_en, rf_addr, rf_d_in, rd_valid, rd_id, rd_data,
                         exp_g, exp_we, exp_a, exp_d, m_rdv, m_rid, m_rdd);
                n_err++;
            end
            if (acc)
                $display("cycle %0d: requester %0d %s addr=%0d", cyc, m_owner, exp_we ? "write" : "read", exp_a);
            // Advance the model across the coming rising edge.
            if (m_owner < 0) begin
                m_rdv = 1'b0;
                if (req != 3'b000) begin
                    for (int k = 0; k < 3; k++) begin
                        if (m_owner < 0 && req[(m_start + k) % 3]) m_owner = (m_start + k) % 3;
                    end
                    m_served = 0;
                end
            end else if (acc) begin
                m_served++;
                if (exp_we) begin
                    ref_mem[exp_a] = exp_d;
                    m_rdv = 1'b0;
                end else begin
                    m_rdd = ref_mem[exp_a];
                    m_rid = 2'(m_owner);
                    m_rdv = 1'b1;
                end
                if (m_served == MAX_HOLD) begin
                    m_start = (m_owner + 1) % 3;
                    m_owner = -1;
                end
            end else begin
                m_rdv   = 1'b0;
                m_start = (m_owner + 1) % 3;
                m_owner = -1;
            end
            @(negedge clk);
        end
        $display("test_random done");
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_round_robin();
        test_loader_write();
        test_exec_read();
        test_reset_mid_grant();
        test_drop_release();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
